spi_minion_arbiter: RTL

//  Round-robin burst arbiter in front of the FFT/SPI interconnect datapath.

---
 rtl/spi_minion_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_minion_arbiter.sv
// Round-robin burst arbiter sharing one downstream val/rdy message port among
// NREQ SPI minion front-ends, with burst limit and idle-timeout release.
module spi_minion_arbiter #(
    parameter int NREQ         = 3,
    parameter int MSG_W        = 18,
    parameter int BURST_LEN    = 8,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          en_mask,
    input  logic [NREQ-1:0]          req_val,
    input  logic [NREQ*MSG_W-1:0]    req_msg,
    output logic [NREQ-1:0]          req_rdy,
    output logic                     out_val,
    output logic [MSG_W-1:0]         out_msg,
    input  logic                     out_rdy,
    output logic                     grant_vld,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int ID_W   = $clog2(NREQ);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic {ARB, GRANT} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [ID_W-1:0]     gnt, gnt_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
    logic                sel_val;
    logic [MSG_W-1:0]    sel_msg;
    logic [NREQ-1:0]     cand;
    logic                found;
    logic                fire;
    int                  idx;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        if (int'(id) >= NREQ - 1) return '0;
        return id + 1'b1;
    endfunction

    // Lane currently holding the grant
    always_comb begin
        sel_val = 1'b0;
        sel_msg = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == ID_W'(i)) begin
                sel_val = req_val[i];
                sel_msg = req_msg[i*MSG_W +: MSG_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        beat_nxt  = beat_cnt;
        idle_nxt  = idle_cnt;
        cand      = req_val & en_mask;
        found     = 1'b0;
        fire      = 1'b0;
        idx       = 0;
        out_val   = 1'b0;
        out_msg   = '0;
        req_rdy   = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        case (state)
            ARB: begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = int'(ptr) + k;
                    if (idx >= NREQ) idx = idx - NREQ;
                    if (!found && cand[idx]) begin
                        found   = 1'b1;
                        gnt_nxt = ID_W'(idx);
                    end
                end
                if (found) begin
                    state_nxt = GRANT;
                    beat_nxt  = '0;
                    idle_nxt  = '0;
                end
            end
            GRANT: begin
                grant_vld = 1'b1;
                grant_id  = gnt;
                out_val   = sel_val;
                out_msg   = sel_msg;
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt == ID_W'(i)) req_rdy[i] = out_rdy;
                end
                fire     = sel_val & out_rdy;
                if (fire) beat_nxt = beat_cnt + 1'b1;
                idle_nxt = sel_val ? '0 : idle_cnt + 1'b1;
                // Burst exhausted or requester idle too long: always bubble through ARB
                if ((fire && beat_cnt == BEAT_LAST) || (!sel_val && idle_cnt == IDLE_LAST)) begin
                    state_nxt = ARB;
                    ptr_nxt   = wrap_inc(gnt);
                    beat_nxt  = '0;
                    idle_nxt  = '0;
                end
            end
            default: state_nxt = ARB;
        endcase
        // Nothing may transfer while reset is held, even mid-burst
        if (reset) begin
            out_val   = 1'b0;
            out_msg   = '0;
            req_rdy   = '0;
            grant_vld = 1'b0;
            grant_id  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            ptr      <= '0;
            gnt      <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            beat_cnt <= beat_nxt;
            idle_cnt <= idle_nxt;
        end
    end

endmodule
